// File: rtl/hazard_load_scoreboard_pkg.sv
// hazard_load_scoreboard_pkg: shared types and helpers for the load-use scoreboard
package hazard_load_scoreboard_pkg;
   typedef enum logic [1:0] {MEM_NONE, MEM_READ, MEM_WRITE} memaccess_t;
   typedef enum logic {SB_RUN, SB_DRAIN} sb_state_t;
   localparam int LD_MAX_DEFAULT = 2;
   function automatic logic [31:0] onehot(input logic [4:0] r);
      return (32'd1 << r) & ~32'd1;
   endfunction
endpackage

// File: rtl/hazard_load_scoreboard_if.sv
// hazard_load_scoreboard_if: D-stage request, W-stage completion and scoreboard status bundle
interface hazard_load_scoreboard_if;
   import hazard_load_scoreboard_pkg::*;
   logic valid_d, regwrite_d, fence_d, use_rs1_d, use_rs2_d, flush_d, ld_done_w;
   memaccess_t memaccess_d;
   logic [4:0] rs1_d, rs2_d, rd_d, ld_rd_w;
   logic stall_d, flush_e, sb_err;
   logic [31:0] pending, stall_raw_cnt, stall_cap_cnt;
   logic [2:0] ld_count;
   modport master (
      output valid_d, regwrite_d, memaccess_d, fence_d, rs1_d, rs2_d, use_rs1_d, use_rs2_d, rd_d, flush_d,
             ld_done_w, ld_rd_w,
      input  stall_d, flush_e, pending, ld_count, sb_err, stall_raw_cnt, stall_cap_cnt
   );
   modport slave (
      input  valid_d, regwrite_d, memaccess_d, fence_d, rs1_d, rs2_d, use_rs1_d, use_rs2_d, rd_d, flush_d,
             ld_done_w, ld_rd_w,
      output stall_d, flush_e, pending, ld_count, sb_err, stall_raw_cnt, stall_cap_cnt
   );
endinterface

// File: rtl/hazard_pending_table.sv
// hazard_pending_table: per-register pending-load bits with same-cycle clear bypass; set wins, x0 never pending
module hazard_pending_table
   import hazard_load_scoreboard_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        set_en,
   input  logic        clr_en,
   input  logic [4:0]  set_rd,
   input  logic [4:0]  clr_rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [4:0]  rd,
   output logic [31:0] pending,
   output logic        eff_rs1,
   output logic        eff_rs2,
   output logic        eff_rd,
   output logic        pend_clr
);
   logic [31:0] eff;
   assign eff      = pending & ~(clr_en ? onehot(clr_rd) : '0);
   assign eff_rs1  = eff[rs1];
   assign eff_rs2  = eff[rs2];
   assign eff_rd   = eff[rd];
   assign pend_clr = pending[clr_rd];
   always_ff @(posedge clk)
      if (reset) pending <= '0;
      else pending <= eff | (set_en ? onehot(set_rd) : '0);
endmodule

// File: rtl/hazard_load_scoreboard.sv
// hazard_load_scoreboard: stalls D on load-use, load WAW, outstanding-load cap and FENCE drain.
// Optional perf counters with `HAZARD_SB_PERF_EN.
module hazard_load_scoreboard
   import hazard_load_scoreboard_pkg::*;
#(
   parameter int LD_MAX = LD_MAX_DEFAULT
) (
   input logic clk,
   input logic reset,
   hazard_load_scoreboard_if.slave sb
);
   sb_state_t state;
   logic is_ld, raw, waw, cap, fen, iss, dec, err, e1, e2, erd, pclr;
   logic [2:0] cnt_next;
   hazard_pending_table u_tbl (
      .clk(clk), .reset(reset), .set_en(iss), .clr_en(sb.ld_done_w), .set_rd(sb.rd_d), .clr_rd(sb.ld_rd_w),
      .rs1(sb.rs1_d), .rs2(sb.rs2_d), .rd(sb.rd_d), .pending(sb.pending),
      .eff_rs1(e1), .eff_rs2(e2), .eff_rd(erd), .pend_clr(pclr)
   );
   always_comb begin
      is_ld      = sb.valid_d & sb.regwrite_d & (sb.memaccess_d == MEM_READ) & (sb.rd_d != 5'd0);
      raw        = (sb.use_rs1_d & e1) | (sb.use_rs2_d & e2);
      waw        = is_ld & erd;
      cap        = is_ld & ((sb.ld_count - {2'b0, sb.ld_done_w}) == 3'(LD_MAX));
      fen        = sb.fence_d & ((state == SB_DRAIN) | (sb.ld_count != 3'd0));
      sb.stall_d = sb.valid_d & ~sb.flush_d & (raw | waw | cap | fen);
      sb.flush_e = sb.stall_d;
      iss        = is_ld & ~sb.stall_d & ~sb.flush_d;
      // a bogus completion never drives the count below zero
      dec        = sb.ld_done_w & (sb.ld_count != 3'd0);
      err        = sb.ld_done_w & ((sb.ld_count == 3'd0) | ~pclr | (sb.ld_rd_w == 5'd0));
      cnt_next   = sb.ld_count + {2'b0, iss} - {2'b0, dec};
   end
   always_ff @(posedge clk)
      if (reset) begin
         state       <= SB_RUN;
         sb.ld_count <= '0;
         sb.sb_err   <= 1'b0;
      end else begin
         sb.ld_count <= cnt_next;
         sb.sb_err   <= sb.sb_err | err;
         state       <= (state == SB_RUN)
                        ? ((sb.fence_d & sb.valid_d & ~sb.flush_d & (sb.ld_count != 3'd0)) ? SB_DRAIN : SB_RUN)
                        : (((cnt_next == 3'd0) | sb.flush_d) ? SB_RUN : SB_DRAIN);
      end
`ifdef HAZARD_SB_PERF_EN
   always_ff @(posedge clk)
      if (reset) begin
         sb.stall_raw_cnt <= '0;
         sb.stall_cap_cnt <= '0;
      end else begin
         if (sb.stall_d & raw & ~&sb.stall_raw_cnt) sb.stall_raw_cnt <= sb.stall_raw_cnt + 32'd1;
         if (sb.stall_d & ~raw & (waw | cap | fen) & ~&sb.stall_cap_cnt) sb.stall_cap_cnt <= sb.stall_cap_cnt + 32'd1;
      end
`else
   assign sb.stall_raw_cnt = '0;
   assign sb.stall_cap_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_load_scoreboard.sv
// tb_hazard_load_scoreboard: scenario tasks against a cycle model; expected state queued per driven cycle
module tb_hazard_load_scoreboard;
   import hazard_load_scoreboard_pkg::*;
   localparam int LDM = 2;
`ifdef HAZARD_SB_PERF_EN
   localparam bit PERF_ON = 1'b1;
`else
   localparam bit PERF_ON = 1'b0;
`endif
   logic clk = 1'b0, reset = 1'b1;
   always #5 clk = ~clk;
   hazard_load_scoreboard_if sb ();
   hazard_load_scoreboard #(.LD_MAX(LDM)) dut (.clk(clk), .reset(reset), .sb(sb));

   typedef struct {
      string       tag;
      logic [31:0] pend;
      logic [2:0]  cnt;
      logic        err;
      logic [31:0] raw_c;
      logic [31:0] cap_c;
   } exp_t;
   exp_t q[$];
   int errors = 0, checks = 0;
   bit [31:0] m_pend;
   int m_cnt;
   bit m_drain, m_err;
   int unsigned m_raw, m_cap;

   task automatic drive_idle();
      sb.valid_d = 0; sb.regwrite_d = 0; sb.memaccess_d = MEM_NONE; sb.fence_d = 0;
      sb.use_rs1_d = 0; sb.rs1_d = 0; sb.use_rs2_d = 0; sb.rs2_d = 0; sb.rd_d = 0;
      sb.flush_d = 0; sb.ld_done_w = 0; sb.ld_rd_w = 0;
   endtask

   task automatic cyc(input string tag, input bit v, rw, ld, fn, u1, input logic [4:0] r1, input bit u2,
                      input logic [4:0] r2, rd, input bit fl, dn, input logic [4:0] drd);
      bit [31:0] clr, eff;
      bit isld, raw, waw, cap, fen, stall, iss;
      int nxt;
      exp_t e;
      @(negedge clk);
      sb.valid_d = v; sb.regwrite_d = rw; sb.memaccess_d = ld ? MEM_READ : MEM_NONE; sb.fence_d = fn;
      sb.use_rs1_d = u1; sb.rs1_d = r1; sb.use_rs2_d = u2; sb.rs2_d = r2; sb.rd_d = rd;
      sb.flush_d = fl; sb.ld_done_w = dn; sb.ld_rd_w = drd;
      clr   = (dn && drd != 0) ? (32'd1 << drd) : 32'd0;
      eff   = m_pend & ~clr;
      isld  = v && rw && ld && rd != 0;
      raw   = (u1 && eff[r1]) || (u2 && eff[r2]);
      waw   = isld && eff[rd];
      cap   = isld && (m_cnt - int'(dn)) == LDM;
      fen   = fn && (m_drain || m_cnt != 0);
      stall = v && !fl && (raw || waw || cap || fen);
      #1;
      checks++;
      if (sb.stall_d !== stall) begin
         errors++; $display("FAIL %s stall_d got=%b exp=%b", tag, sb.stall_d, stall);
      end
      checks++;
      if (sb.flush_e !== stall) begin
         errors++; $display("FAIL %s flush_e got=%b exp=%b", tag, sb.flush_e, stall);
      end
      iss = isld && !stall && !fl;
      if (dn && (m_cnt == 0 || !m_pend[drd] || drd == 0)) m_err = 1;
      if (stall && raw) m_raw++;
      else if (stall && (waw || cap || fen)) m_cap++;
      nxt = m_cnt + int'(iss) - int'(dn && m_cnt > 0);
      m_drain = m_drain ? !(nxt == 0 || fl) : (fn && v && !fl && m_cnt != 0);
      m_pend = eff | (iss ? (32'd1 << rd) : 32'd0);
      m_cnt = nxt;
      q.push_back('{tag, m_pend, 3'(m_cnt), m_err, PERF_ON ? m_raw : 0, PERF_ON ? m_cap : 0});
      @(posedge clk);
      #1;
      e = q.pop_front();
      checks++;
      if (sb.pending !== e.pend) begin
         errors++; $display("FAIL %s pending got=%h exp=%h", e.tag, sb.pending, e.pend);
      end
      checks++;
      if (sb.ld_count !== e.cnt) begin
         errors++; $display("FAIL %s ld_count got=%0d exp=%0d", e.tag, sb.ld_count, e.cnt);
      end
      checks++;
      if (sb.sb_err !== e.err) begin
         errors++; $display("FAIL %s sb_err got=%b exp=%b", e.tag, sb.sb_err, e.err);
      end
      checks++;
      if (sb.stall_raw_cnt !== e.raw_c) begin
         errors++; $display("FAIL %s stall_raw_cnt got=%0d exp=%0d", e.tag, sb.stall_raw_cnt, e.raw_c);
      end
      checks++;
      if (sb.stall_cap_cnt !== e.cap_c) begin
         errors++; $display("FAIL %s stall_cap_cnt got=%0d exp=%0d", e.tag, sb.stall_cap_cnt, e.cap_c);
      end
   endtask

   task automatic load(input string tag, input logic [4:0] rd, input bit dn = 0, input logic [4:0] drd = 0);
      cyc(tag, 1, 1, 1, 0, 0, 0, 0, 0, rd, 0, dn, drd);
   endtask
   task automatic use1(input string tag, input logic [4:0] r, input bit dn = 0, input logic [4:0] drd = 0);
      cyc(tag, 1, 0, 0, 0, 1, r, 0, 0, 0, 0, dn, drd);
   endtask
   task automatic use2(input string tag, input logic [4:0] r, input bit dn = 0, input logic [4:0] drd = 0);
      cyc(tag, 1, 0, 0, 0, 0, 0, 1, r, 0, 0, dn, drd);
   endtask
   task automatic fence(input string tag, input bit fl = 0, input bit dn = 0, input logic [4:0] drd = 0);
      cyc(tag, 1, 0, 0, 1, 0, 0, 0, 0, 0, fl, dn, drd);
   endtask
   task automatic idle(input string tag, input bit dn = 0, input logic [4:0] drd = 0);
      cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, dn, drd);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset = 1'b1;
      drive_idle();
      @(posedge clk);
      #1;
      checks++;
      if (sb.pending !== 32'd0 || sb.ld_count !== 3'd0 || sb.sb_err !== 1'b0) begin
         errors++;
         $display("FAIL %s state got pend=%h cnt=%0d err=%b exp 0/0/0", tag, sb.pending, sb.ld_count, sb.sb_err);
      end
      checks++;
      if (sb.stall_d !== 1'b0 || sb.flush_e !== 1'b0) begin
         errors++; $display("FAIL %s stall/flush got=%b%b exp=00", tag, sb.stall_d, sb.flush_e);
      end
      checks++;
      if (sb.stall_raw_cnt !== 32'd0 || sb.stall_cap_cnt !== 32'd0) begin
         errors++; $display("FAIL %s perf got=%0d/%0d exp=0/0", tag, sb.stall_raw_cnt, sb.stall_cap_cnt);
      end
      reset = 1'b0;
      m_pend = 0; m_cnt = 0; m_drain = 0; m_err = 0; m_raw = 0; m_cap = 0;
   endtask

   task automatic test_reset();
      do_reset("reset");
   endtask

   task automatic test_raw();
      load("raw_ld5", 5);
      use1("raw_use5_a", 5);
      use1("raw_use5_b", 5);
      use1("raw_use5_done", 5, 1, 5);
   endtask

   task automatic test_x0();
      load("x0_ld", 0);
      use1("x0_use", 0);
      use2("x0_use2", 0);
   endtask

   task automatic test_cap();
      load("cap_ld1", 1);
      load("cap_ld2", 2);
      load("cap_ld3_stall", 3);
      load("cap_ld3_done1", 3, 1, 1);
      checks++;
      if (sb.ld_count !== 3'd2) begin
         errors++; $display("FAIL cap_count got=%0d exp=2", sb.ld_count);
      end
      idle("cap_done2", 1, 2);
      idle("cap_done3", 1, 3);
   endtask

   task automatic test_waw();
      load("waw_ld7", 7);
      load("waw_ld7_stall", 7);
      load("waw_ld7_swap", 7, 1, 7);
      checks++;
      if (sb.pending[7] !== 1'b1 || sb.ld_count !== 3'd1) begin
         errors++; $display("FAIL waw_swap got pend7=%b cnt=%0d exp 1/1", sb.pending[7], sb.ld_count);
      end
      idle("waw_done7", 1, 7);
   endtask

   task automatic test_fence();
      load("fen_ld1", 1);
      load("fen_ld2", 2);
      fence("fen_wait");
      fence("fen_done1", 0, 1, 1);
      fence("fen_done2", 0, 1, 2);
      fence("fen_go");
      load("fen_ld3", 3);
      load("fen_ld4", 4);
      fence("fen_wait2");
      fence("fen_flush", 1);
      idle("fen_done3", 1, 3);
      idle("fen_done4", 1, 4);
   endtask

   task automatic test_err();
      idle("err_orphan", 1, 6);
      idle("err_hold");
      load("err_ld8", 8);
      idle("err_nopend", 1, 9);
      do_reset("err_reset");
      idle("err_after_reset", 1, 8);
      do_reset("err_reset2");
   endtask

   task automatic test_perf();
      load("perf_ld9", 9);
      use2("perf_use_a", 9);
      use2("perf_use_b", 9);
      use2("perf_use_c", 9);
      use2("perf_done", 9, 1, 9);
      checks++;
      if (sb.stall_raw_cnt !== (PERF_ON ? 32'd3 : 32'd0)) begin
         errors++; $display("FAIL perf_raw3 got=%0d exp=%0d", sb.stall_raw_cnt, PERF_ON ? 3 : 0);
      end
   endtask

   task automatic test_back_to_back();
      load("b2b_ld10", 10);
      load("b2b_ld11", 11);
      cyc("b2b_flushed_ld", 1, 1, 1, 0, 0, 0, 0, 0, 12, 1, 0, 0);
      use1("b2b_use10_done", 10, 1, 10);
      use2("b2b_use11", 11);
      use2("b2b_use11_done", 11, 1, 11);
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_raw();
      test_x0();
      test_cap();
      test_waw();
      test_fence();
      test_back_to_back();
      test_err();
      test_perf();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
